// File: rtl/pcm_frame_scheduler_if.sv
// Stereo sample bus between the tracker mixer, the frame scheduler and the PCM serializer.
// Ports: src_left/src_right/src_valid/src_ready carry producer pairs into the scheduler;
//        pcm_data_left/pcm_data_right/pcm_data_valid carry the frame pair out to the serializer.
interface pcm_frame_scheduler_if;
    logic [15:0] src_left;
    logic [15:0] src_right;
    logic        src_valid;
    logic        src_ready;
    logic [15:0] pcm_data_left;
    logic [15:0] pcm_data_right;
    logic        pcm_data_valid;

    // Environment side: drives producer pairs, observes the serializer outputs.
    modport master (
        output src_left, src_right, src_valid,
        input  src_ready,
        input  pcm_data_left, pcm_data_right, pcm_data_valid
    );

    // Scheduler side.
    modport slave (
        input  src_left, src_right, src_valid,
        output src_ready,
        output pcm_data_left, pcm_data_right, pcm_data_valid
    );
endinterface

// File: rtl/pcm_frame_scheduler.sv
// Frame-level scheduler for the stereo PCM serializer: buffers producer pairs in a small FIFO and
// presents one pair per frame, held stable across the serializer load edge.
// Ports: bit_clock_in/rst_active_high (async, active-high), enable, bus (slave: src_* in, pcm_data_* out),
//        frame_strobe (load cycle), fifo_level, underrun_count (saturating), running (RUN state).
module pcm_frame_scheduler #(
    parameter int FRAME_BITS       = 32,
    parameter int FIFO_DEPTH       = 4,
    parameter int PRIME_LEVEL      = 2,
    parameter int MUTE_ON_UNDERRUN = 1
) (
    input  logic                               bit_clock_in,
    input  logic                               rst_active_high,
    input  logic                               enable,
    pcm_frame_scheduler_if.slave               bus,
    output logic                               frame_strobe,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic [7:0]                         underrun_count,
    output logic                               running
);
    localparam int CW = $clog2(FRAME_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   frame_cnt;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;
    logic [31:0]     mem [FIFO_DEPTH];
    logic [15:0]     out_left, out_right;
    logic            out_valid;
    logic [7:0]      urun_cnt;

    logic boundary, pop_edge, flush, push, pop, underrun, ready;

    // frame_cnt runs in every state so it stays in lock-step with the serializer bit counter;
    // FRAME_BITS is a power of two, so the natural wrap gives FRAME_BITS-1 -> 0.
    always_ff @(posedge bit_clock_in or posedge rst_active_high) begin
        if (rst_active_high) frame_cnt <= '0;
        else                 frame_cnt <= frame_cnt + CW'(1);
    end

    assign boundary = (frame_cnt == CW'(FRAME_BITS - 1));
    assign pop_edge = (frame_cnt == '0);

    assign ready    = (state_q != IDLE) && (level < LW'(FIFO_DEPTH));
    // A flushing boundary edge discards any simultaneous push.
    assign flush    = boundary && !enable;
    assign push     = bus.src_valid && ready && !flush;
    // No bypass: a pair pushed on the pop edge is not visible to that pop.
    assign pop      = (state_q == RUN) && pop_edge && (level != '0);
    assign underrun = (state_q == RUN) && pop_edge && (level == '0);

    always_comb begin
        state_d = state_q;
        if (boundary) begin
            if (!enable)
                state_d = IDLE;
            else if (state_q == IDLE)
                state_d = PRIME;
            else if (state_q == PRIME && level >= LW'(PRIME_LEVEL))
                state_d = RUN;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge bit_clock_in) begin
        if (push) mem[wr_ptr] <= {bus.src_left, bus.src_right};
    end

    always_ff @(posedge bit_clock_in or posedge rst_active_high) begin
        if (rst_active_high) begin
            state_q   <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            urun_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                out_left  <= '0;
                out_right <= '0;
                out_valid <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop) begin
                    rd_ptr                <= rd_ptr + PW'(1);
                    {out_left, out_right} <= mem[rd_ptr];
                    out_valid             <= 1'b1;
                end
                if (underrun) begin
                    if (urun_cnt != 8'hFF) urun_cnt <= urun_cnt + 8'd1;
                    // Muting lets the serializer shift zeros; otherwise the last pair repeats.
                    if (MUTE_ON_UNDERRUN != 0) out_valid <= 1'b0;
                end
                case ({push, pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    assign bus.src_ready      = ready;
    assign bus.pcm_data_left  = out_left;
    assign bus.pcm_data_right = out_right;
    assign bus.pcm_data_valid = out_valid;
    assign frame_strobe       = boundary;
    assign fifo_level         = level;
    assign underrun_count     = urun_cnt;
    assign running            = (state_q == RUN);
endmodule

// File: tb/tb_pcm_frame_scheduler.sv
// Directed bench for pcm_frame_scheduler: three instances (muting, repeating, deep priming)
// share clock and reset; stimulus is a linear sequence with hand-computed expectations.
module tb_pcm_frame_scheduler;
    logic clk = 1'b0;
    logic rst;
    logic en, en2;
    logic [15:0] s_left, s_right, s2_left, s2_right;
    logic s_valid, s2_valid;
    int cyc;
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pcm_frame_scheduler_if if0 ();
    pcm_frame_scheduler_if if1 ();
    pcm_frame_scheduler_if if2 ();

    assign if0.src_left  = s_left;
    assign if0.src_right = s_right;
    assign if0.src_valid = s_valid;
    assign if1.src_left  = s_left;
    assign if1.src_right = s_right;
    assign if1.src_valid = s_valid;
    assign if2.src_left  = s2_left;
    assign if2.src_right = s2_right;
    assign if2.src_valid = s2_valid;

    logic       strobe0, strobe1, strobe2, run0, run1, run2;
    logic [2:0] lvl0, lvl1, lvl2;
    logic [7:0] ur0, ur1, ur2;

    pcm_frame_scheduler #(.FRAME_BITS(32), .FIFO_DEPTH(4), .PRIME_LEVEL(2), .MUTE_ON_UNDERRUN(1)) u0 (
        .bit_clock_in(clk), .rst_active_high(rst), .enable(en), .bus(if0),
        .frame_strobe(strobe0), .fifo_level(lvl0), .underrun_count(ur0), .running(run0));
    pcm_frame_scheduler #(.FRAME_BITS(32), .FIFO_DEPTH(4), .PRIME_LEVEL(2), .MUTE_ON_UNDERRUN(0)) u1 (
        .bit_clock_in(clk), .rst_active_high(rst), .enable(en), .bus(if1),
        .frame_strobe(strobe1), .fifo_level(lvl1), .underrun_count(ur1), .running(run1));
    pcm_frame_scheduler #(.FRAME_BITS(32), .FIFO_DEPTH(4), .PRIME_LEVEL(4), .MUTE_ON_UNDERRUN(1)) u2 (
        .bit_clock_in(clk), .rst_active_high(rst), .enable(en2), .bus(if2),
        .frame_strobe(strobe2), .fifo_level(lvl2), .underrun_count(ur2), .running(run2));

    logic [31:0] tbl [5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later; cyc is the frame_cnt-aligned cycle index.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // Release lands on a negedge so the following cycle is cycle 0 with frame_cnt = 0.
    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic rdy;
        int   idx;
        tbl[0] = 32'h1234_5678;
        tbl[1] = 32'h9ABC_DEF0;
        tbl[2] = 32'h0F0F_F0F0;
        tbl[3] = 32'hCAFE_BEEF;
        tbl[4] = 32'h5555_5555;
        rst = 1'b1; en = 1'b0; en2 = 1'b0;
        s_valid = 1'b0; s_left = '0; s_right = '0;
        s2_valid = 1'b0; s2_left = '0; s2_right = '0;
        cyc = 0;

        // Reset values, before any clock edge.
        #2;
        chk("rst_strobe",  strobe0, 0);
        chk("rst_ready",   if0.src_ready, 0);
        chk("rst_valid",   if0.pcm_data_valid, 0);
        chk("rst_data",    {if0.pcm_data_left, if0.pcm_data_right}, 0);
        chk("rst_level",   lvl0, 0);
        chk("rst_urun",    ur0, 0);
        chk("rst_running", run0, 0);

        // Enable low for 100 cycles: strobe only on frame position 31.
        apply_reset();
        for (int c = 0; c < 100; c++) begin
            chk("idle_strobe", strobe0, ((cyc % 32) == 31) ? 1 : 0);
            tick();
        end
        chk("idle_ready",   if0.src_ready, 0);
        chk("idle_valid",   if0.pcm_data_valid, 0);
        chk("idle_running", run0, 0);

        // Prime with two pairs, run, output one pair per frame, then underrun.
        apply_reset();
        run_to(5);
        en = 1'b1;
        run_to(31);
        chk("b_strobe31", strobe0, 1);
        chk("b_ready_idle", if0.src_ready, 0);
        tick();                                    // cycle 32: PRIME
        chk("b_prime_running", run0, 0);
        chk("b_prime_ready", if0.src_ready, 1);
        s_valid = 1'b1; s_left = 16'h1111; s_right = 16'hAAAA;
        tick();
        s_left = 16'h2222; s_right = 16'hBBBB;
        tick();                                    // cycle 34
        s_valid = 1'b0;
        chk("b_level2", lvl0, 2);
        run_to(63);
        chk("b_still_prime", run0, 0);
        tick();                                    // cycle 64: RUN, pop not yet taken
        chk("b_run", run0, 1);
        chk("b_valid64", if0.pcm_data_valid, 0);
        tick();                                    // cycle 65
        chk("b_pair1", {if0.pcm_data_valid, if0.pcm_data_left, if0.pcm_data_right}, 33'h1_1111_AAAA);
        chk("b_level1", lvl0, 1);
        for (int c = 66; c <= 96; c++) begin
            tick();
            chk("b_pair1_stable", {if0.pcm_data_valid, if0.pcm_data_left, if0.pcm_data_right}, 33'h1_1111_AAAA);
        end
        tick();                                    // cycle 97
        chk("b_pair2", {if0.pcm_data_valid, if0.pcm_data_left, if0.pcm_data_right}, 33'h1_2222_BBBB);
        chk("b_pair2_rep", {if1.pcm_data_valid, if1.pcm_data_left, if1.pcm_data_right}, 33'h1_2222_BBBB);
        chk("b_level0", lvl0, 0);
        run_to(128);
        chk("b_urun_before", ur0, 0);
        tick();                                    // cycle 129: first underrun
        chk("b_urun_mute", ur0, 1);
        chk("b_mute_out", {if0.pcm_data_valid, if0.pcm_data_left, if0.pcm_data_right}, 33'h0_2222_BBBB);
        chk("b_urun_rep", ur1, 1);
        chk("b_rep_out", {if1.pcm_data_valid, if1.pcm_data_left, if1.pcm_data_right}, 33'h1_2222_BBBB);

        // Deep priming: continuous src_valid fills to 4, no overwrite, order preserved.
        en = 1'b0; en2 = 1'b1;
        apply_reset();
        run_to(32);
        chk("c_ready", if2.src_ready, 1);
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            s2_valid = 1'b1;
            {s2_left, s2_right} = tbl[idx];
            rdy = if2.src_ready;
            tick();
            if (rdy) idx++;
        end
        s2_valid = 1'b0;
        chk("c_full_level", lvl2, 4);
        chk("c_full_ready", if2.src_ready, 0);
        chk("c_accepted", idx, 4);
        run_to(63);
        chk("c_prime", run2, 0);
        run_to(65);
        chk("c_pop0", {if2.pcm_data_valid, if2.pcm_data_left, if2.pcm_data_right}, {1'b1, tbl[0]});
        chk("c_level3", lvl2, 3);
        run_to(97);
        chk("c_pop1", {if2.pcm_data_left, if2.pcm_data_right}, tbl[1]);
        run_to(129);
        chk("c_pop2", {if2.pcm_data_left, if2.pcm_data_right}, tbl[2]);
        run_to(161);
        chk("c_pop3", {if2.pcm_data_left, if2.pcm_data_right}, tbl[3]);
        chk("c_level0", lvl2, 0);

        // Enable dropped mid-frame with 3 queued: nothing moves until the boundary flush.
        en2 = 1'b0; en = 1'b1;
        apply_reset();
        run_to(32);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            {s_left, s_right} = tbl[i];
            tick();
        end
        s_valid = 1'b0;
        chk("d_level4", lvl0, 4);
        chk("d_ready_full", if0.src_ready, 0);
        run_to(65);
        chk("d_level3", lvl0, 3);
        chk("d_out0", {if0.pcm_data_left, if0.pcm_data_right}, tbl[0]);
        run_to(70);
        en = 1'b0;
        run_to(95);
        chk("d_hold_level", lvl0, 3);
        chk("d_hold_out", {if0.pcm_data_valid, if0.pcm_data_left, if0.pcm_data_right}, {1'b1, tbl[0]});
        chk("d_hold_running", run0, 1);
        chk("d_ready", if0.src_ready, 1);
        s_valid = 1'b1; s_left = 16'h9999; s_right = 16'h8888;
        tick();                                    // cycle 96: flushed, push discarded
        s_valid = 1'b0;
        chk("d_flush_level", lvl0, 0);
        chk("d_flush_out", {if0.pcm_data_valid, if0.pcm_data_left, if0.pcm_data_right}, 0);
        chk("d_flush_idle", run0, 0);
        chk("d_flush_ready", if0.src_ready, 0);
        chk("d_flush_rep_out", {if1.pcm_data_valid, if1.pcm_data_left, if1.pcm_data_right}, 0);

        // Long underrun run: counter saturates at 255; then asynchronous reset mid-frame.
        en = 1'b1;
        apply_reset();
        run_to(32);
        s_valid = 1'b1; {s_left, s_right} = tbl[0];
        tick();
        {s_left, s_right} = tbl[1];
        tick();
        s_valid = 1'b0;
        run_to(8256);
        chk("e_urun254", ur0, 254);
        tick();
        chk("e_urun255", ur0, 255);
        run_to(10000);
        chk("e_sat_mute", ur0, 255);
        chk("e_sat_rep", ur1, 255);
        chk("e_mute_valid", if0.pcm_data_valid, 0);
        chk("e_rep_out", {if1.pcm_data_valid, if1.pcm_data_left, if1.pcm_data_right}, {1'b1, tbl[1]});
        run_to(10015);
        chk("e_strobe_pre", strobe0, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("e_arst_strobe",  strobe0, 0);
        chk("e_arst_urun",    ur0, 0);
        chk("e_arst_running", run0, 0);
        chk("e_arst_ready",   if0.src_ready, 0);
        chk("e_arst_out",     {if0.pcm_data_valid, if0.pcm_data_left, if0.pcm_data_right}, 0);
        chk("e_arst_rep_out", {if1.pcm_data_valid, if1.pcm_data_left, if1.pcm_data_right}, 0);
        chk("e_arst_rep_urun", ur1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
